// File: rtl/popcount_accumulator.sv
// Popcount accumulator: sums per-word popcounts over a vector delimited by in_last
// and hands the sum, the word count and the bipolar dot product downstream over valid/ready.
module popcount_accumulator #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6:0]         in_cnt,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [CNT_W-1:0]   out_words,
  output logic [ACC_W:0]     out_dot,
  output logic               out_err
);

  localparam int DOT_W = ACC_W + 1;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   words_q, words_d;
  logic               err_q, err_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_words_q, out_words_d;
  logic [DOT_W-1:0]   out_dot_q, out_dot_d;
  logic               out_err_q, out_err_d;

  logic               accept;
  logic [ACC_W:0]     sum_ext;
  logic               sat_acc;
  logic               sat_words;
  logic [ACC_W-1:0]   acc_nxt;
  logic [CNT_W-1:0]   words_nxt;
  logic               err_nxt;
  logic [DOT_W-1:0]   dot_nxt;

  // In HOLD a new beat may enter only in the cycle the pending result is consumed.
  assign in_ready = (state_q == ACCUM) || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    sum_ext   = {1'b0, acc_q} + (ACC_W+1)'(in_cnt);
    sat_acc   = sum_ext[ACC_W];
    acc_nxt   = sat_acc ? '1 : sum_ext[ACC_W-1:0];
    sat_words = &words_q;
    words_nxt = sat_words ? words_q : words_q + CNT_W'(1);
    err_nxt   = err_q || sat_acc || sat_words || (in_cnt > 7'd64);
    // Modular arithmetic in DOT_W bits yields the exact two's complement result.
    dot_nxt   = {acc_nxt, 1'b0} - DOT_W'({words_nxt, 6'b000000});
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    words_d     = words_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_words_d = out_words_q;
    out_dot_d   = out_dot_q;
    out_err_d   = out_err_q;

    if (state_q == HOLD && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = ACCUM;
    end

    if (accept) begin
      if (in_last) begin
        out_sum_d   = acc_nxt;
        out_words_d = words_nxt;
        out_dot_d   = dot_nxt;
        out_err_d   = err_nxt;
        out_valid_d = 1'b1;
        state_d     = HOLD;
        acc_d       = '0;
        words_d     = '0;
        err_d       = 1'b0;
      end else begin
        acc_d   = acc_nxt;
        words_d = words_nxt;
        err_d   = err_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      words_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_words_q <= '0;
      out_dot_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      words_q     <= words_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_words_q <= out_words_d;
      out_dot_q   <= out_dot_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_words = out_words_q;
  assign out_dot   = out_dot_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_popcount_accumulator.sv
// Directed bench for popcount_accumulator with hand-computed expectations.
module tb_popcount_accumulator;

  localparam int ACC_W = 16;
  localparam int CNT_W = 10;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [6:0]         in_cnt;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_sum;
  logic [CNT_W-1:0]   out_words;
  logic [ACC_W:0]     out_dot;
  logic               out_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  popcount_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cnt    (in_cnt),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_words (out_words),
    .out_dot   (out_dot),
    .out_err   (out_err)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs were set shortly after the previous edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [6:0] c, input logic l);
    in_valid = 1'b1;
    in_cnt   = c;
    in_last  = l;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_cnt   = '0;
    in_last  = 1'b0;
  endtask

  task automatic chk_result(input string tag, input longint s, input longint w,
                            input longint d, input longint e);
    chk({tag, "_valid"}, longint'(out_valid), 1);
    chk({tag, "_sum"},   longint'(out_sum), s);
    chk({tag, "_words"}, longint'(out_words), w);
    chk({tag, "_dot"},   longint'($signed(out_dot)), d);
    chk({tag, "_err"},   longint'(out_err), e);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    idle();
    #1;

    // Reset and idle
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_ready", longint'(in_ready), 1);
    chk("rst_sum",   longint'(out_sum), 0);
    chk("rst_words", longint'(out_words), 0);
    chk("rst_dot",   longint'(out_dot), 0);
    chk("rst_err",   longint'(out_err), 0);

    // Three-word vector 64, 32, 0
    out_ready = 1'b1;
    beat(7'd64, 1'b0); tick();
    beat(7'd32, 1'b0); tick();
    chk("v3_novalid", longint'(out_valid), 0);
    beat(7'd0, 1'b1); tick();
    idle();
    chk_result("v3", 96, 3, 0, 0);
    tick();
    chk("v3_drop", longint'(out_valid), 0);

    // Back-to-back single-word vectors
    beat(7'd1, 1'b1);
    #1 chk("b2b_rdy0", longint'(in_ready), 1);
    tick();
    chk_result("b2b0", 1, 1, -62, 0);
    beat(7'd64, 1'b1);
    #1 chk("b2b_rdy1", longint'(in_ready), 1);
    tick();
    chk_result("b2b1", 64, 1, 64, 0);
    beat(7'd10, 1'b1);
    #1 chk("b2b_rdy2", longint'(in_ready), 1);
    tick();
    chk_result("b2b2", 10, 1, -44, 0);
    idle();
    tick();
    chk("b2b_drop", longint'(out_valid), 0);

    // Backpressure: 5, 7 then a waiting beat of 20
    out_ready = 1'b0;
    beat(7'd5, 1'b0); tick();
    beat(7'd7, 1'b1); tick();
    chk_result("bp", 12, 2, -104, 0);
    beat(7'd20, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("bp_stall_rdy", longint'(in_ready), 0);
      tick();
      chk_result("bp_hold", 12, 2, -104, 0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_rdy", longint'(in_ready), 1);
    tick();
    chk("bp_consumed", longint'(out_valid), 0);
    beat(7'd4, 1'b1); tick();
    idle();
    chk_result("bp_fresh", 24, 2, -80, 0);
    tick();
    chk("bp_drop", longint'(out_valid), 0);

    // Word counter saturation: 1025 beats of 64
    for (int i = 0; i < 1025; i++) begin
      beat(7'd64, (i == 1024) ? 1'b1 : 1'b0);
      tick();
    end
    idle();
    chk("sat_valid", longint'(out_valid), 1);
    chk("sat_words", longint'(out_words), 1023);
    chk("sat_sum",   longint'(out_sum), 65535);
    chk("sat_err",   longint'(out_err), 1);
    tick();

    // Illegal popcount value
    beat(7'd70, 1'b1); tick();
    idle();
    chk_result("big", 70, 1, 76, 1);
    tick();

    // Error flag does not leak into the next vector
    beat(7'd64, 1'b1); tick();
    idle();
    chk_result("clean", 64, 1, 64, 0);
    tick();

    // Reset mid-vector discards the partial sum
    beat(7'd40, 1'b0); tick();
    beat(7'd40, 1'b0); tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_ready", longint'(in_ready), 1);
    tick();
    chk("mid_rst_stale", longint'(out_valid), 0);
    beat(7'd8, 1'b1); tick();
    idle();
    chk_result("mid_rst", 8, 1, -48, 0);
    tick();
    chk("mid_rst_drop", longint'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
